// File: rtl/cs_loader.sv
// cs_loader: copies microcode ROM into control-store RAM at 2 cycles/word, no backpressure.
// Optional readback verify pass (another 2 cycles/word) is built when CS_LOADER_VERIFY_EN is defined.
module cs_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] cs_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] cs_data_in,
  output logic                  cs_ram__w,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  cs_ready,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
`ifdef CS_LOADER_VERIFY_EN
    , S_VREAD,
    S_VCMP,
    S_ERROR
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  r_we_n;
  logic                  w_we_n_nxt;
  logic                  r_ready;
  logic                  w_addr_top;

`ifdef CS_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0] r_rom_q;
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] w_rom_q_nxt;
  logic [DATA_WIDTH-1:0] w_ram_q_nxt;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [ADDR_WIDTH-1:0] w_err_addr_nxt;
  logic                  r_err;
`else
  logic                  w_unused_ram;
  assign w_unused_ram = ^ram_data;
`endif

  assign w_addr_top = &r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we_n_nxt  = 1'b1;
`ifdef CS_LOADER_VERIFY_EN
    w_rom_q_nxt    = r_rom_q;
    w_ram_q_nxt    = r_ram_q;
    w_err_addr_nxt = r_err_addr;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
          w_addr_nxt  = '0;
        end
      end
      S_READ: begin
        w_data_nxt  = rom_data;
        w_we_n_nxt  = 1'b0;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (w_addr_top) begin
`ifdef CS_LOADER_VERIFY_EN
          w_addr_nxt  = '0;
          w_state_nxt = S_VREAD;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = S_READ;
        end
      end
`ifdef CS_LOADER_VERIFY_EN
      S_VREAD: begin
        w_rom_q_nxt = rom_data;
        w_ram_q_nxt = ram_data;
        w_state_nxt = S_VCMP;
      end
      S_VCMP: begin
        // The address is left on the failing word so the fault can be inspected in place.
        if (r_rom_q != r_ram_q) begin
          w_err_addr_nxt = r_addr;
          w_state_nxt    = S_ERROR;
        end else if (w_addr_top) begin
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = S_VREAD;
        end
      end
      S_ERROR: w_state_nxt = S_ERROR;
`endif
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_we_n  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_we_n  <= w_we_n_nxt;
      r_ready <= (w_state_nxt == S_DONE);
    end
  end

`ifdef CS_LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_q    <= '0;
      r_ram_q    <= '0;
      r_err_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rom_q    <= w_rom_q_nxt;
      r_ram_q    <= w_ram_q_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_err      <= (w_state_nxt == S_ERROR);
    end
  end

  assign load_error = r_err;
  assign err_addr   = r_err_addr;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
`else
  assign load_error = 1'b0;
  assign err_addr   = '0;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
`endif

  assign cs_addr    = r_addr;
  assign cs_data_in = r_data;
  assign cs_ram__w  = r_we_n;
  assign cs_ready   = r_ready;

endmodule

// File: doc/cs_loader.md
CS_LOADER -- requirements
Module: cs_loader

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 8, giving the control store address width (2^ADDR_WIDTH words).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64, giving the microword width.
REQ-003 Port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: level request to begin loading; sampled only in IDLE.
REQ-006 Port cs_addr, output, ADDR_WIDTH bits: shared address to microcode ROM and RAM.
REQ-007 Port rom_data, input, DATA_WIDTH bits: ROM read data, valid one cycle after cs_addr changes.
REQ-008 Port cs_data_in, output, DATA_WIDTH bits: registered write data to control store RAM.
REQ-009 Port cs_ram__w, output, 1 bit: registered, active-low RAM write strobe.
REQ-010 Port ram_data, input, DATA_WIDTH bits: RAM readback data, valid one cycle after cs_addr changes.
REQ-011 Port busy, output, 1 bit: high in any state other than IDLE, DONE or ERROR.
REQ-012 Port cs_ready, output, 1 bit: registered; high only in DONE.
REQ-013 Port load_error, output, 1 bit: registered; high only in ERROR.
REQ-014 Port err_addr, output, ADDR_WIDTH bits: address of the first verify mismatch.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, WRITE, VREAD, VCMP, DONE and ERROR.
REQ-016 IDLE with start=1 at a clock edge SHALL move to READ with cs_addr=0; with start=0 it SHALL stay in IDLE.
REQ-017 READ SHALL last one cycle. At its closing edge, the module SHALL register rom_data into cs_data_in, drive cs_ram__w=0 and enter WRITE.
REQ-018 WRITE SHALL last one cycle with cs_ram__w=0, and cs_addr and cs_data_in stable for the whole cycle.
- At its closing edge, cs_ram__w SHALL return to 1.
- If cs_addr is not all-ones, cs_addr SHALL increment and the FSM SHALL enter READ.
- If cs_addr is all-ones, cs_addr SHALL wrap to 0 and the FSM SHALL enter VREAD when verify is compiled in, otherwise DONE.
REQ-019 Each copied word SHALL take exactly 2 cycles. Without verify, cs_ready SHALL rise at the edge 2*2^ADDR_WIDTH cycles after the start-sampling edge.
REQ-020 VREAD SHALL last one cycle. At its closing edge, the module SHALL register rom_data and ram_data internally and enter VCMP.
REQ-021 VCMP SHALL compare the two registered words.
- On mismatch: latch cs_addr into err_addr and enter ERROR.
- On match with cs_addr not all-ones: increment cs_addr and enter VREAD.
- On match with cs_addr all-ones: enter DONE.
REQ-022 DONE and ERROR SHALL be terminal: start SHALL be ignored, and only reset SHALL exit them.
REQ-023 cs_ram__w SHALL be 1 in every state except WRITE.
REQ-024 cs_ram__w SHALL never be 0 for more than one cycle per address.
REQ-025 cs_addr SHALL hold its value in DONE (all-ones without verify, last-verified address with verify) and SHALL freeze at the failing address in ERROR.

Reset
REQ-026 While reset=1, the module SHALL force, asynchronously: state=IDLE, cs_addr=0, cs_data_in=0, cs_ram__w=1, busy=0, cs_ready=0, load_error=0, err_addr=0.
REQ-027 Reset asserted mid-copy or mid-verify SHALL abort immediately with no further write strobe.
REQ-028 After reset deassertion, the module SHALL restart from address 0 on the next start.

Configuration
REQ-029 Macro CS_LOADER_VERIFY_EN defined: VREAD/VCMP are present and the full readback pass runs before DONE (total 4*2^ADDR_WIDTH cycles).
REQ-030 Macro CS_LOADER_VERIFY_EN undefined: VREAD, VCMP and ERROR are omitted, load_error and err_addr are tied to 0, and WRITE at the top address goes directly to DONE.

Verification
REQ-031 ADDR_WIDTH=4, verify off, ROM word[i]=i*0x0101010101010101, start pulsed 1 cycle -> 16 single-cycle cs_ram__w pulses at addresses 0..15 with matching data; cs_ready rises exactly 32 cycles after the start edge.
REQ-032 ADDR_WIDTH=4, verify on, RAM model stores correctly -> cs_ready rises at cycle 64; load_error stays 0.
REQ-033 ADDR_WIDTH=4, verify on, RAM model corrupts bit 0 of address 0x9 -> load_error=1, err_addr=0x9, cs_ready=0, cs_addr frozen at 0x9.
REQ-034 reset asserted in WRITE at address 0x5 -> cs_ram__w=1, cs_addr=0, busy=0 with no clock edge; after release, start -> copy restarts at address 0.
REQ-035 start held high continuously after DONE -> no further write strobes; cs_ready stays 1 for 100 cycles.
REQ-036 start=0 for 50 cycles after reset -> state remains IDLE, cs_ram__w=1, cs_addr=0.
